// File: rtl/tess_domain_norm.sv
`timescale 1ns/1ps
// Tessellation domain normaliser: turns integer barycentric (i,j) into Q1.FRAC (u,v,w)
// using a per-patch reciprocal of the level from a serial restoring divider.
module tess_domain_norm #(
    parameter int FIFO_DEPTH = 16,
    parameter int FRAC       = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      tess_level,
    input  logic            in_valid,
    input  logic [7:0]      in_i,
    input  logic [7:0]      in_j,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FRAC:0]   out_u,
    output logic [FRAC:0]   out_v,
    output logic [FRAC:0]   out_w,
    output logic            out_last,
    output logic            busy,
    output logic            overflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PTRW = AW + 1;
    localparam int RW   = FRAC + 9;
    localparam int PW   = FRAC + 17;
    localparam int CW   = $clog2(FRAC + 9);

    localparam logic [CW-1:0] CNT_LAST = CW'(FRAC + 8);
    localparam logic [FRAC:0] ONE_O    = {1'b1, {FRAC{1'b0}}};
    localparam logic [PW-1:0] ONE_P    = PW'(1) << (FRAC + 8);

    logic [1:0]      state;
    logic [7:0]      lc;
    logic [RW-1:0]   rcp;
    logic [7:0]      rem;
    logic [CW-1:0]   cnt;

    logic [16:0]     mem [FIFO_DEPTH];
    logic [PTRW-1:0] wptr, rptr;
    logic            full, empty, push, pop, drop;
    logic [16:0]     rd;

    logic            s1_valid, s1_last;
    logic [PW-1:0]   s1_pu, s1_pv;
    logic            s1_ready, s2_ready, done;

    logic [8:0]      div_r;
    logic            qbit;
    logic [7:0]      rem_nx;
    logic [FRAC:0]   u_c, v_c, w_c;
    logic [FRAC+1:0] uv_sum;

    assign busy     = (state != ST_IDLE);
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd       = mem[rptr[AW-1:0]];

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign pop      = (state == ST_RUN) && !empty && s1_ready;
    assign push     = in_valid && (state != ST_IDLE) && (!full || pop);
    assign drop     = in_valid && !push;
    assign done     = (state == ST_RUN) && out_valid && out_ready && out_last;

    // Dividend is 2^(FRAC+8)-1 (a zero then all ones, MSB first); adding one to
    // the final quotient gives the ceiling of 2^(FRAC+8)/Lc.
    always_comb begin
        div_r  = {rem, (cnt != '0)};
        qbit   = (div_r >= {1'b0, lc});
        rem_nx = qbit ? 8'(div_r - {1'b0, lc}) : div_r[7:0];
    end

    always_comb begin
        u_c    = (s1_pu >= ONE_P) ? ONE_O : {1'b0, s1_pu[FRAC+7:8]};
        v_c    = (s1_pv >= ONE_P) ? ONE_O : {1'b0, s1_pv[FRAC+7:8]};
        uv_sum = {1'b0, u_c} + {1'b0, v_c};
        w_c    = (uv_sum >= {1'b0, ONE_O}) ? '0 : ONE_O - uv_sum[FRAC:0];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= {in_i, in_j, in_last};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lc        <= 8'd1;
            rcp       <= '0;
            rem       <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_pu     <= '0;
            s1_pv     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_u     <= '0;
            out_v     <= '0;
            out_w     <= '0;
        end else begin
            if (push) wptr <= wptr + PTRW'(1);
            if (pop)  rptr <= rptr + PTRW'(1);

            if (drop)
                overflow <= 1'b1;
            else if (state == ST_IDLE && start)
                overflow <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lc    <= (tess_level == 8'd0) ? 8'd1 : tess_level;
                        rem   <= '0;
                        cnt   <= '0;
                        rcp   <= '0;
                        state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    rem <= rem_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        rcp   <= {rcp[RW-2:0], qbit} + RW'(1);
                        state <= ST_RUN;
                    end else begin
                        rcp <= {rcp[RW-2:0], qbit};
                    end
                end
                ST_RUN: begin
                    if (done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (s1_ready) begin
                s1_valid <= pop;
                if (pop) begin
                    s1_pu   <= PW'(rd[16:9]) * PW'(rcp);
                    s1_pv   <= PW'(rd[8:1]) * PW'(rcp);
                    s1_last <= rd[0];
                end
            end

            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_u    <= u_c;
                    out_v    <= v_c;
                    out_w    <= w_c;
                    out_last <= s1_last;
                end
            end

            // End of patch: anything still queued behind the last point is discarded.
            if (done) begin
                wptr      <= '0;
                rptr      <= '0;
                s1_valid  <= 1'b0;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tess_domain_norm.sv
`timescale 1ns/1ps
// Directed bench for tess_domain_norm: a reference model queue checks every
// handshaken output, plus hand-computed values at the interesting points.
module tb_tess_domain_norm;

    localparam int FRAC = 15;
    localparam int ONE  = 32768;

    logic        clk, rst, start, in_valid, in_last, out_valid, out_ready, out_last, busy, overflow;
    logic [7:0]  tess_level, in_i, in_j;
    logic [15:0] out_u, out_v, out_w;

    tess_domain_norm #(.FIFO_DEPTH(16), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .tess_level(tess_level),
        .in_valid(in_valid), .in_i(in_i), .in_j(in_j), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_u(out_u), .out_v(out_v), .out_w(out_w), .out_last(out_last),
        .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] u;
        logic [15:0] v;
        logic [15:0] w;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp, n_bad, n_out, npts;
    int          pi[64], pj[64];
    bit          pl[64];
    logic [15:0] got_u[64], got_v[64], got_w[64];
    logic        got_last[64];

    task automatic check(input string tag, input longint got, input longint expv);
        n_cmp++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic exp_t model(input int i, input int j, input bit last, input int l);
        exp_t   e;
        longint lcm, rcp, u, v, w;
        lcm = (l == 0) ? 1 : l;
        rcp = ((64'd1 << 23) + lcm - 1) / lcm;
        u = (i * rcp) >> 8;
        v = (j * rcp) >> 8;
        if (u > ONE) u = ONE;
        if (v > ONE) v = ONE;
        w = ONE - u - v;
        if (w < 0) w = 0;
        e.u = 16'(u);
        e.v = 16'(v);
        e.w = 16'(w);
        e.last = last;
        return e;
    endfunction

    // Output monitor: scoreboard on handshakes, stability while stalled.
    initial begin
        bit          stalled;
        logic [15:0] hu, hv, hw;
        logic        hl;
        exp_t        e;
        stalled = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_u", out_u, hu);
                    check("hold_v", out_v, hv);
                    check("hold_w", out_w, hw);
                    check("hold_last", out_last, hl);
                end
                stalled = out_valid && !out_ready;
                hu = out_u; hv = out_v; hw = out_w; hl = out_last;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_u", out_u, e.u);
                        check("out_v", out_v, e.v);
                        check("out_w", out_w, e.w);
                        check("out_last", out_last, e.last);
                    end
                    if (n_out < 64) begin
                        got_u[n_out] = out_u; got_v[n_out] = out_v;
                        got_w[n_out] = out_w; got_last[n_out] = out_last;
                    end
                    n_out++;
                end
            end
        end
    end

    task automatic mk_tri(input int l);
        npts = 0;
        for (int i = 0; i <= l; i++)
            for (int j = 0; j <= l - i; j++) begin
                pi[npts] = i; pj[npts] = j; pl[npts] = 0;
                npts++;
            end
        pl[npts-1] = 1;
    endtask

    task automatic do_start(input int l);
        tess_level = 8'(l);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int n, input int drop_idx, input int l);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_i = 8'(pi[k]);
            in_j = 8'(pj[k]);
            in_last = pl[k];
            if (k != drop_idx) exp_q.push_back(model(pi[k], pj[k], pl[k], l));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_outs(input int target, input string tag);
        int c;
        c = 0;
        while (n_out < target && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        check(tag, n_out, target);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_bad = 0; n_out = 0;
        rst = 1'b1; start = 1'b0; tess_level = '0;
        in_valid = 1'b0; in_i = '0; in_j = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_u", out_u, 0);
        check("rst_last", out_last, 0);
        @(posedge clk); #1;

        // L=4, full triangle streamed from the cycle after start
        mk_tri(4); n_out = 0;
        do_start(4);
        check("t1_busy", busy, 1);
        send(15, -1, 4);
        wait_outs(15, "t1_count");
        check("t1_u0", got_u[0], 0);
        check("t1_v0", got_v[0], 0);
        check("t1_w0", got_w[0], 32768);
        check("t1_u7", got_u[7], 8192);
        check("t1_v7", got_v[7], 16384);
        check("t1_w7", got_w[7], 8192);
        check("t1_u14", got_u[14], 32768);
        check("t1_w14", got_w[14], 0);
        check("t1_last14", got_last[14], 1);
        check("t1_last13", got_last[13], 0);
        check("t1_ovf", overflow, 0);

        // L=255, 17 points during DIV: the 17th is dropped
        for (int k = 0; k < 17; k++) begin
            pi[k] = (k * 17) % 256; pj[k] = 0; pl[k] = (k == 15);
        end
        n_out = 0;
        do_start(255);
        send(17, 16, 255);
        check("t2_ovf", overflow, 1);
        wait_outs(16, "t2_count");
        check("t2_u0", got_u[0], 0);
        check("t2_u1", got_u[1], 2184);
        check("t2_u15", got_u[15], 32768);
        check("t2_w15", got_w[15], 0);
        check("t2_last15", got_last[15], 1);
        check("t2_sticky", overflow, 1);

        // tess_level=0 behaves as L=1
        pi[0] = 0; pj[0] = 0; pl[0] = 0;
        pi[1] = 0; pj[1] = 1; pl[1] = 0;
        pi[2] = 1; pj[2] = 0; pl[2] = 1;
        n_out = 0;
        do_start(0);
        check("t3_ovf_clr", overflow, 0);
        send(3, -1, 0);
        wait_outs(3, "t3_count");
        check("t3_w0", got_w[0], 32768);
        check("t3_v1", got_v[1], 32768);
        check("t3_u2", got_u[2], 32768);
        check("t3_last1", got_last[1], 0);
        check("t3_last2", got_last[2], 1);

        // L=3 with backpressure, plus a start pulse during RUN
        mk_tri(3); n_out = 0;
        do_start(3);
        fork
            send(10, -1, 3);
            begin
                for (int k = 0; k < 80; k++) begin
                    @(posedge clk); #1;
                    out_ready = (k >= 30 && k < 35) ? 1'b0 : (k % 2 == 0);
                end
                out_ready = 1'b1;
            end
            begin
                repeat (28) @(posedge clk);
                #1 start = 1'b1; tess_level = 8'd7;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        wait_outs(10, "t4_count");
        check("t4_u4", got_u[4], 10922);
        check("t4_w4", got_w[4], 21846);
        check("t4_v5", got_v[5], 10922);
        check("t4_w5", got_w[5], 10924);
        check("t4_u9", got_u[9], 32768);
        check("t4_last9", got_last[9], 1);

        // Reset three cycles into RUN, then a clean L=2 patch
        mk_tri(4); n_out = 0;
        do_start(4);
        send(15, -1, 4);
        repeat (12) @(posedge clk);
        #1;
        check("t5_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        mk_tri(2); n_out = 0;
        rst = 1'b0;
        do_start(2);
        send(6, -1, 2);
        wait_outs(6, "t5_count");
        check("t5_w3", got_w[3], 16384);
        check("t5_u4", got_u[4], 16384);
        check("t5_v4", got_v[4], 16384);
        check("t5_w4", got_w[4], 0);
        check("t5_v2", got_v[2], 32768);
        check("t5_u5", got_u[5], 32768);
        check("t5_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
